// File: rtl/hazard_pkg.sv
// Shared constants, FSM encodings and control-word type for the EX-stage
// hazard controller and its mul/div sequencer.
package hazard_pkg;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int MD_TIMEOUT_DEFAULT = 64;
    localparam int CNT_W_DEFAULT      = 32;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } pipe_ctrl_t;

    // Free-running pipeline: every register advances, nothing is squashed.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        if_id_flush:   1'b0,
        id_ex_write:   1'b1,
        id_ex_flush:   1'b0,
        ex_mem_bubble: 1'b0
    };

    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used
    );
        return mem_read && (rd != REG_X0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; the master drives the
// ID/EX hazard info and md_done, the slave (controller) drives the enables.
interface ex_hazard_ctrl_if #(
    parameter int CNT_W = hazard_pkg::CNT_W_DEFAULT
);
    logic             MemRead_ex;
    logic [4:0]       rdAddr_ex;
    logic [4:0]       rs1Addr_id;
    logic [4:0]       rs2Addr_id;
    logic             rs1Used_id;
    logic             rs2Used_id;
    logic             JumpFlag_ex;
    logic             MulDiv_ex;
    logic             md_done;
    logic             PC_IFWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Write;
    logic             ID_EX_Flush;
    logic             EX_MEM_Bubble;
    logic             md_start;
    logic             md_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
               rs2Used_id, JumpFlag_ex, MulDiv_ex, md_done,
        input  PC_IFWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Bubble, md_start, md_timeout, stall_cnt
    );

    modport slave (
        input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id,
               rs2Used_id, JumpFlag_ex, MulDiv_ex, md_done,
        output PC_IFWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
               EX_MEM_Bubble, md_start, md_timeout, stall_cnt
    );

endinterface

// File: rtl/ex_hazard_ctrl_muldiv_seq.sv
// Mul/div sequencer: start pulse, freeze request while the unit iterates,
// and forced release with a sticky error flag if md_done never arrives.
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic md_req,
    input  logic md_done,
    output logic md_start,
    output logic md_freeze,
    output logic md_busy,
    output logic md_timeout
);

    localparam int                TO_W    = $clog2(MD_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MD_TIMEOUT - 1);

    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            md_timeout_q, md_timeout_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        md_timeout_d = md_timeout_q;
        md_start     = 1'b0;
        md_freeze    = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_req) begin
                    md_start  = 1'b1;
                    md_freeze = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    md_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    md_freeze = 1'b1;
                    if (to_cnt_q != {TO_W{1'b1}}) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign md_busy    = (state_q == MD_BUSY);
    assign md_timeout = md_timeout_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage pipeline controller: load-use bubble, taken-branch flush,
// mul/div freeze sequencing and a stall-cycle performance counter.
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    ex_hazard_ctrl_if.slave bus
);

    logic             md_start_raw;
    logic             md_freeze;
    logic             md_busy;
    logic             md_timeout;
    logic             load_use;
    pipe_ctrl_t       ctrl;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    muldiv_seq #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_muldiv_seq (
        .clk        (clk),
        .reset      (reset),
        .md_req     (bus.MulDiv_ex),
        .md_done    (bus.md_done),
        .md_start   (md_start_raw),
        .md_freeze  (md_freeze),
        .md_busy    (md_busy),
        .md_timeout (md_timeout)
    );

    assign load_use = load_use_hit(bus.MemRead_ex, bus.rdAddr_ex, bus.rs1Addr_id,
                                   bus.rs2Addr_id, bus.rs1Used_id, bus.rs2Used_id);

    // Priority: mul/div freeze, then jump flush (ID instr is wrong-path), then load-use.
    // The release cycle of a mul/div leaves the pipeline running untouched.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!reset) begin
            if (md_freeze) begin
                ctrl.pc_write      = 1'b0;
                ctrl.if_id_write   = 1'b0;
                ctrl.id_ex_write   = 1'b0;
                ctrl.ex_mem_bubble = 1'b1;
            end else if (!md_busy) begin
                if (bus.JumpFlag_ex) begin
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.if_id_write = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(!ctrl.pc_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_IFWrite    = ctrl.pc_write;
    assign bus.IF_ID_Write   = ctrl.if_id_write;
    assign bus.IF_ID_Flush   = ctrl.if_id_flush;
    assign bus.ID_EX_Write   = ctrl.id_ex_write;
    assign bus.ID_EX_Flush   = ctrl.id_ex_flush;
    assign bus.EX_MEM_Bubble = ctrl.ex_mem_bubble;
    // Start pulse is masked while reset is held so a pending mul is never re-issued.
    assign bus.md_start      = md_start_raw && !reset;
    assign bus.md_timeout    = md_timeout;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed scenarios then random traffic,
// expected outputs from a cycle-level behavioural model of the hazard rules.
module tb_ex_hazard_ctrl;

    localparam int MD_TO = 16;
    localparam int CW    = 8;

    typedef struct {
        bit       reset;
        bit       mem_read;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       rs1_used;
        bit       rs2_used;
        bit       jump;
        bit       muldiv;
        bit       md_done;
    } stim_t;

    typedef struct {
        bit pc_w;
        bit ifid_w;
        bit ifid_f;
        bit idex_w;
        bit idex_f;
        bit bubble;
        bit md_start;
        bit md_timeout;
        int stall;
    } exp_t;

    logic clk;
    logic reset;

    ex_hazard_ctrl_if #(.CNT_W(CW)) bus();

    ex_hazard_ctrl #(
        .MD_TIMEOUT (MD_TO),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: whether a mul/div is in flight, how many cycles it
    // has frozen the pipe so far, the sticky timeout flag and the stall tally.
    bit m_busy    = 1'b0;
    int m_frozen  = 0;
    bit m_timeout = 1'b0;
    int m_stall   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t noisy();
        stim_t s;
        s          = quiet();
        s.jump     = ($urandom_range(0, 7) == 0);
        s.mem_read = ($urandom_range(0, 2) == 0);
        s.rd       = 5'($urandom_range(0, 3));
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.rs1_used = 1'($urandom_range(0, 1));
        s.rs2_used = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset            = s.reset;
        bus.MemRead_ex   = s.mem_read;
        bus.rdAddr_ex    = s.rd;
        bus.rs1Addr_id   = s.rs1;
        bus.rs2Addr_id   = s.rs2;
        bus.rs1Used_id   = s.rs1_used;
        bus.rs2Used_id   = s.rs2_used;
        bus.JumpFlag_ex  = s.jump;
        bus.MulDiv_ex    = s.muldiv;
        bus.md_done      = s.md_done;

        e = '{pc_w: 1, ifid_w: 1, ifid_f: 0, idex_w: 1, idex_f: 0, bubble: 0,
              md_start: 0, md_timeout: m_timeout, stall: m_stall};
        if (s.reset) begin
            e.md_timeout = 0;
            e.stall      = 0;
            m_busy       = 0;
            m_frozen     = 0;
            m_timeout    = 0;
            m_stall      = 0;
        end else if (!m_busy) begin
            if (s.muldiv) begin
                e.pc_w = 0; e.ifid_w = 0; e.idex_w = 0; e.bubble = 1;
                e.md_start = 1;
                m_busy     = 1;
                m_frozen   = 1;
            end else if (s.jump) begin
                e.ifid_f = 1;
                e.idex_f = 1;
            end else if (s.mem_read && s.rd != 0 &&
                         ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd))) begin
                e.pc_w   = 0;
                e.ifid_w = 0;
                e.idex_f = 1;
            end
        end else if (s.md_done) begin
            m_busy = 0;
        end else if (m_frozen == MD_TO) begin
            m_busy    = 0;
            m_timeout = 1;
        end else begin
            e.pc_w = 0; e.ifid_w = 0; e.idex_w = 0; e.bubble = 1;
            m_frozen++;
        end
        if (!e.pc_w) m_stall = (m_stall + 1) % (1 << CW);
        sb_q.push_back(e);
    endtask

    // Start a mul/div, keep it in EX for n_busy further cycles with hazard noise
    // on the other inputs, optionally pulsing md_done on the last one.
    task automatic muldiv_op(input int n_busy, input bit done_last);
        stim_t s;
        s        = quiet();
        s.muldiv = 1;
        drive(s);
        for (int i = 1; i <= n_busy; i++) begin
            s         = noisy();
            s.muldiv  = 1;
            s.md_done = done_last && (i == n_busy);
            drive(s);
        end
    endtask

    // Monitor: compares each queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctrl",
                      {25'd0, bus.PC_IFWrite, bus.IF_ID_Write, bus.IF_ID_Flush,
                       bus.ID_EX_Write, bus.ID_EX_Flush, bus.EX_MEM_Bubble, bus.md_start},
                      {25'd0, e.pc_w, e.ifid_w, e.ifid_f, e.idex_w, e.idex_f, e.bubble, e.md_start});
                check("md_timeout", {31'd0, bus.md_timeout}, {31'd0, e.md_timeout});
                check("stall_cnt", {24'd0, bus.stall_cnt}, e.stall);
            end
        end
    end

    initial begin
        stim_t s;
        reset           = 1'b1;
        bus.MemRead_ex  = 1'b0;
        bus.rdAddr_ex   = 5'd0;
        bus.rs1Addr_id  = 5'd0;
        bus.rs2Addr_id  = 5'd0;
        bus.rs1Used_id  = 1'b0;
        bus.rs2Used_id  = 1'b0;
        bus.JumpFlag_ex = 1'b0;
        bus.MulDiv_ex   = 1'b0;
        bus.md_done     = 1'b0;

        s = quiet(); s.reset = 1;
        drive(s);
        drive(s);
        drive(quiet());

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble
        s = quiet(); s.mem_read = 1; s.rd = 5; s.rs1 = 5; s.rs2 = 1; s.rs1_used = 1; s.rs2_used = 1;
        drive(s);
        drive(quiet());
        // destination x0 never stalls
        s.rd = 0; s.rs1 = 0;
        drive(s);
        drive(quiet());
        // rs2 match, then rs2 match with rs2 unused
        s = quiet(); s.mem_read = 1; s.rd = 9; s.rs2 = 9; s.rs2_used = 1;
        drive(s);
        s.rs2_used = 0;
        drive(s);
        // jump together with a load-use match
        s = quiet(); s.mem_read = 1; s.rd = 7; s.rs1 = 7; s.rs1_used = 1; s.jump = 1;
        drive(s);
        drive(quiet());

        muldiv_op(8, 1);          // done 8 cycles after start
        drive(quiet());
        muldiv_op(4, 1);          // back-to-back mul, mul
        muldiv_op(5, 1);
        drive(quiet());
        muldiv_op(MD_TO, 0);      // md_done never arrives
        drive(quiet());
        drive(quiet());
        muldiv_op(2, 0);          // reset on the third busy cycle
        s = quiet(); s.reset = 1; s.muldiv = 1;
        drive(s);
        drive(quiet());
        drive(quiet());

        for (int n = 0; n < 3000; n++) begin
            s = noisy();
            if (m_busy) begin
                s.muldiv  = 1;
                s.md_done = ($urandom_range(0, 9) == 0);
            end else begin
                s.muldiv  = ($urandom_range(0, 15) == 0);
                s.md_done = ($urandom_range(0, 9) == 0);
                if (s.muldiv) begin
                    s.jump     = 0;
                    s.mem_read = 0;
                end
            end
            s.reset = ($urandom_range(0, 299) == 0);
            drive(s);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #3;
        check("drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
